// File: rtl/trigger_pulse_gen_usb_pkg.sv
// Shared definitions for the USB trigger pulse generator: default counter
// widths (also used by the register block) and the FSM state encoding.
package trigger_pulse_gen_usb_pkg;

    localparam int DEF_DELAY_WIDTH = 20;
    localparam int DEF_PULSE_WIDTH = 17;
    localparam int DEF_NUM_WIDTH   = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_PULSE = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

endpackage

// File: rtl/trigger_pulse_gen_usb_if.sv
// Control/config inputs and trigger/status outputs of the pulse generator.
// slave = generator side, master = register block / matcher side.
interface trigger_pulse_gen_usb_if
    import trigger_pulse_gen_usb_pkg::*;
#(
    parameter int pDELAY_WIDTH = DEF_DELAY_WIDTH,
    parameter int pPULSE_WIDTH = DEF_PULSE_WIDTH,
    parameter int pNUM_WIDTH   = DEF_NUM_WIDTH
);
    logic                    arm;
    logic                    match_trigger;
    logic [pDELAY_WIDTH-1:0] delay;
    logic [pPULSE_WIDTH-1:0] width;
    logic [pDELAY_WIDTH-1:0] gap;
    logic [pNUM_WIDTH-1:0]   num_pulses;
    logic                    trigger;
    logic                    armed;
    logic                    busy;
    logic                    done;

    modport master (
        output arm, match_trigger, delay, width, gap, num_pulses,
        input  trigger, armed, busy, done
    );

    modport slave (
        input  arm, match_trigger, delay, width, gap, num_pulses,
        output trigger, armed, busy, done
    );
endinterface

// File: rtl/trigger_pulse_gen_usb_cnt.sv
// Loadable down-counter timing the delay, pulse-high and gap phases.
// Stops at zero; the FSM acts on is_one so a phase lasts exactly the loaded count.
module trigger_pulse_gen_usb_cnt #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] val,
    output logic         is_one
);
    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= val;
        end else if (dec && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign is_one = (count == W'(1));
endmodule

// File: rtl/trigger_pulse_gen_usb.sv
// Turns a single-cycle match pulse into a delayed, width-controlled, optionally
// repeated trigger train. One train per arm rising edge; arm low aborts.
module trigger_pulse_gen_usb
    import trigger_pulse_gen_usb_pkg::*;
#(
    parameter int pDELAY_WIDTH = DEF_DELAY_WIDTH,
    parameter int pPULSE_WIDTH = DEF_PULSE_WIDTH,
    parameter int pNUM_WIDTH   = DEF_NUM_WIDTH
) (
    input  logic                   trigger_clk,
    input  logic                   reset_i,
    trigger_pulse_gen_usb_if.slave bus
);
    localparam int CW = (pDELAY_WIDTH > pPULSE_WIDTH) ? pDELAY_WIDTH : pPULSE_WIDTH;

    state_t                  state, state_nxt;
    logic                    arm_r, arm_edge;
    logic [pPULSE_WIDTH-1:0] width_q, width_cl;
    logic [pDELAY_WIDTH-1:0] gap_q, gap_cl;
    logic [pNUM_WIDTH-1:0]   left_q, num_cl;
    logic                    cnt_load, cnt_dec, cnt_one;
    logic [CW-1:0]           cnt_val;
    logic                    latch_en, left_dec, done_nxt;
    logic                    trig_q, armed_q, busy_q, done_q;

    assign arm_edge = bus.arm & ~arm_r;
    assign width_cl = (bus.width == '0)      ? pPULSE_WIDTH'(1) : bus.width;
    assign gap_cl   = (bus.gap == '0)        ? pDELAY_WIDTH'(1) : bus.gap;
    assign num_cl   = (bus.num_pulses == '0) ? pNUM_WIDTH'(1)   : bus.num_pulses;

    trigger_pulse_gen_usb_cnt #(.W(CW)) u_cnt (
        .clk    (trigger_clk),
        .rst    (reset_i),
        .load   (cnt_load),
        .dec    (cnt_dec),
        .val    (cnt_val),
        .is_one (cnt_one)
    );

    always_ff @(posedge trigger_clk or posedge reset_i) begin
        if (reset_i) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cnt_val   = '0;
        latch_en  = 1'b0;
        left_dec  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                // a match coinciding with the arm edge is deliberately dropped
                if (arm_edge) state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (!bus.arm) begin
                    state_nxt = ST_IDLE;
                end else if (bus.match_trigger) begin
                    latch_en = 1'b1;
                    cnt_load = 1'b1;
                    if (bus.delay == '0) begin
                        state_nxt = ST_PULSE;
                        cnt_val   = CW'(width_cl);
                    end else begin
                        state_nxt = ST_DELAY;
                        cnt_val   = CW'(bus.delay);
                    end
                end
            end
            ST_DELAY: begin
                if (!bus.arm) begin
                    state_nxt = ST_IDLE;
                end else if (cnt_one) begin
                    state_nxt = ST_PULSE;
                    cnt_load  = 1'b1;
                    cnt_val   = CW'(width_q);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_PULSE: begin
                if (!bus.arm) begin
                    state_nxt = ST_IDLE;
                end else if (cnt_one) begin
                    if (left_q > pNUM_WIDTH'(1)) begin
                        state_nxt = ST_GAP;
                        cnt_load  = 1'b1;
                        cnt_val   = CW'(gap_q);
                        left_dec  = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_GAP: begin
                if (!bus.arm) begin
                    state_nxt = ST_IDLE;
                end else if (cnt_one) begin
                    state_nxt = ST_PULSE;
                    cnt_load  = 1'b1;
                    cnt_val   = CW'(width_q);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Config is captured once at match; later input changes never reach the train.
    always_ff @(posedge trigger_clk or posedge reset_i) begin
        if (reset_i) begin
            arm_r   <= 1'b0;
            width_q <= '0;
            gap_q   <= '0;
            left_q  <= '0;
            trig_q  <= 1'b0;
            armed_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            arm_r <= bus.arm;
            if (latch_en) begin
                width_q <= width_cl;
                gap_q   <= gap_cl;
                left_q  <= num_cl;
            end else if (left_dec) begin
                left_q <= left_q - pNUM_WIDTH'(1);
            end
            trig_q  <= (state_nxt == ST_PULSE);
            armed_q <= (state_nxt == ST_ARMED);
            busy_q  <= (state_nxt inside {ST_DELAY, ST_PULSE, ST_GAP});
            done_q  <= done_nxt;
        end
    end

    assign bus.trigger = trig_q;
    assign bus.armed   = armed_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_trigger_pulse_gen_usb.sv
// Bench for trigger_pulse_gen_usb: directed scenarios plus random traffic,
// every cycle compared against a timing-arithmetic model of the pulse train.
module tb_trigger_pulse_gen_usb;
    localparam int DW = 20;
    localparam int PW = 17;
    localparam int NW = 8;

    logic trigger_clk = 1'b0;
    logic reset_i     = 1'b1;

    trigger_pulse_gen_usb_if bus ();

    trigger_pulse_gen_usb dut (
        .trigger_clk (trigger_clk),
        .reset_i     (reset_i),
        .bus         (bus)
    );

    always #5 trigger_clk = ~trigger_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model: 0 idle, 1 armed, 2 train running since edge m_e0
    int   m_mode = 0;
    logic m_arm_prev = 1'b0;
    int   m_e0, m_d, m_w, m_g, m_n;
    logic m_done, m_trig;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode     = 0;
        m_arm_prev = 1'b0;
        m_done     = 1'b0;
        m_trig     = 1'b0;
    endtask

    // Trigger after edge e is high iff rel = e-e0-d lies in [0, L) and rel mod (w+g) < w,
    // with L = n*(w+g)-g; the train ends with done at rel == L.
    task automatic model_step(input logic a, input logic m);
        logic edge_a;
        int   rel, len;
        m_done     = 1'b0;
        edge_a     = a && !m_arm_prev;
        m_arm_prev = a;
        case (m_mode)
            0: if (edge_a) m_mode = 1;
            1: begin
                if (!a) m_mode = 0;
                else if (m) begin
                    m_e0   = cyc;
                    m_d    = int'(bus.delay);
                    m_w    = (bus.width == 0) ? 1 : int'(bus.width);
                    m_g    = (bus.gap == 0) ? 1 : int'(bus.gap);
                    m_n    = (bus.num_pulses == 0) ? 1 : int'(bus.num_pulses);
                    m_mode = 2;
                end
            end
            default: begin
                len = m_n * (m_w + m_g) - m_g;
                if (!a) m_mode = 0;
                else if (cyc - m_e0 - m_d == len) begin
                    m_mode = 0;
                    m_done = 1'b1;
                end
            end
        endcase
        m_trig = 1'b0;
        if (m_mode == 2) begin
            rel = cyc - m_e0 - m_d;
            if (rel >= 0 && (rel % (m_w + m_g)) < m_w) m_trig = 1'b1;
        end
    endtask

    task automatic step(input logic a, input logic m);
        bus.arm           = a;
        bus.match_trigger = m;
        @(posedge trigger_clk);
        #1;
        cyc++;
        model_step(a, m);
        chk("trigger", 32'(bus.trigger), 32'(m_trig));
        chk("armed",   32'(bus.armed),   32'(m_mode == 1));
        chk("busy",    32'(bus.busy),    32'(m_mode == 2));
        chk("done",    32'(bus.done),    32'(m_done));
    endtask

    task automatic cfg(input int d, input int w, input int g, input int n);
        bus.delay      = DW'(d);
        bus.width      = PW'(w);
        bus.gap        = DW'(g);
        bus.num_pulses = NW'(n);
    endtask

    task automatic run(input logic a, input int cycles);
        for (int i = 0; i < cycles; i++) step(a, 1'b0);
    endtask

    task automatic arm_edge();
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
    endtask

    initial begin
        logic a_cur;
        int   trig_seen;
        bus.arm           = 1'b0;
        bus.match_trigger = 1'b0;
        cfg(0, 1, 1, 1);
        model_reset();

        repeat (2) @(posedge trigger_clk);
        #1;
        chk("rst_trigger", 32'(bus.trigger), 0);
        chk("rst_armed",   32'(bus.armed),   0);
        chk("rst_busy",    32'(bus.busy),    0);
        chk("rst_done",    32'(bus.done),    0);
        @(negedge trigger_clk);
        reset_i = 1'b0;

        // 1: minimal train
        cfg(0, 1, 5, 1);
        arm_edge();
        step(1'b1, 1'b1);
        chk("t1_high_t1", 32'(bus.trigger), 1);
        step(1'b1, 1'b0);
        chk("t1_done_t2", 32'(bus.done), 1);
        run(1'b1, 3);

        // 2: delayed three-pulse train
        cfg(10, 4, 3, 3);
        arm_edge();
        step(1'b1, 1'b1);
        trig_seen = 0;
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b0);
            if (bus.trigger) trig_seen++;
        end
        chk("t2_high_cycles", 32'(trig_seen), 12);

        // 3: zero config clamps to one
        cfg(2, 0, 0, 0);
        arm_edge();
        step(1'b1, 1'b1);
        run(1'b1, 6);

        // 4: abort during second of three pulses
        cfg(1, 3, 2, 3);
        arm_edge();
        step(1'b1, 1'b1);
        run(1'b1, 7);
        chk("t4_in_pulse2", 32'(bus.trigger), 1);
        step(1'b0, 1'b0);
        chk("t4_abort_trig", 32'(bus.trigger), 0);
        run(1'b0, 12);

        // 5: re-match and config change mid-train, then no re-arm on held level
        cfg(5, 2, 1, 2);
        arm_edge();
        step(1'b1, 1'b1);
        run(1'b1, 2);
        cfg(0, 7, 7, 9);
        step(1'b1, 1'b1);
        run(1'b1, 12);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        chk("t5_no_rearm", 32'(bus.busy), 0);
        // arm edge and match in the same cycle: arming only
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        chk("t5_edge_match_armed", 32'(bus.armed), 1);
        step(1'b1, 1'b1);
        run(1'b1, 30);

        // 6: async reset in the middle of a pulse
        cfg(0, 20, 1, 1);
        arm_edge();
        step(1'b1, 1'b1);
        run(1'b1, 3);
        #2;
        reset_i = 1'b1;
        bus.arm = 1'b0;
        #1;
        chk("t6_trig_async", 32'(bus.trigger), 0);
        chk("t6_busy_async", 32'(bus.busy), 0);
        chk("t6_armed_async", 32'(bus.armed), 0);
        chk("t6_done_async", 32'(bus.done), 0);
        @(negedge trigger_clk);
        reset_i = 1'b0;
        model_reset();
        run(1'b0, 2);

        // random traffic; config wiggles every cycle
        a_cur = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (a_cur) a_cur = ($urandom_range(0, 59) != 0);
            else       a_cur = ($urandom_range(0, 2) == 0);
            cfg($urandom_range(0, 6), $urandom_range(0, 4),
                $urandom_range(0, 4), $urandom_range(0, 4));
            step(a_cur, ($urandom_range(0, 5) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
